// File: rtl/run_detector.sv
// Run-length detector: z rises once w has held one value for RUN_LEN enabled samples.
// Binary or one-hot state encoding from one source, plus a saturating detection counter.
module run_detector #(
    parameter int RUN_LEN = 2,
    parameter int ONE_HOT = 0,
    parameter int CNT_W   = 8,
    localparam int NS      = 2*RUN_LEN + 1,
    localparam int STATE_W = (ONE_HOT != 0) ? NS : $clog2(NS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               w,
    input  logic               clr_cnt,
    output logic               z,
    output logic               run_val,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   run_count
);
    localparam int IW = $clog2(NS);

    // State index space: 0 = IDLE, 1..N = Z1..ZN, N+1..2N = O1..ON.
    localparam logic [IW-1:0] Z1     = IW'(1);
    localparam logic [IW-1:0] TERM_Z = IW'(RUN_LEN);
    localparam logic [IW-1:0] O1     = IW'(RUN_LEN + 1);
    localparam logic [IW-1:0] TERM_O = IW'(2*RUN_LEN);
    localparam logic [STATE_W-1:0] IDLE_CODE = (ONE_HOT != 0) ? STATE_W'(1) : '0;

    typedef enum logic [1:0] {K_IDLE, K_ZERO, K_ONE, K_BAD} kind_t;

    logic [STATE_W-1:0] cur_state, nxt_state;
    logic [IW-1:0]      cur_idx, nxt_idx;
    logic               legal;
    logic               inc;
    kind_t              kind;
    logic [CNT_W-1:0]   count;

    // Encoding-specific decode of the register into an index, and encode of the next index.
    generate
        if (ONE_HOT != 0) begin : g_onehot
            always_comb begin
                cur_idx = '0;
                for (int i = 0; i < NS; i++)
                    if (cur_state[i]) cur_idx = IW'(i);
            end
            assign legal     = $onehot(cur_state);
            assign nxt_state = STATE_W'(1) << nxt_idx;
        end else begin : g_binary
            assign cur_idx   = cur_state;
            assign legal     = (cur_state <= STATE_W'(2*RUN_LEN));
            assign nxt_state = nxt_idx;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= IDLE_CODE;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        kind    = K_BAD;
        nxt_idx = cur_idx;
        if (legal) begin
            if (cur_idx == '0)         kind = K_IDLE;
            else if (cur_idx <= TERM_Z) kind = K_ZERO;
            else                        kind = K_ONE;
        end
        // Illegal codes recover to IDLE even while sampling is disabled.
        if (kind == K_BAD) begin
            nxt_idx = '0;
        end else if (en) begin
            if (!w)
                nxt_idx = (kind != K_ZERO) ? Z1 : (cur_idx == TERM_Z) ? TERM_Z : cur_idx + 1'b1;
            else
                nxt_idx = (kind != K_ONE) ? O1 : (cur_idx == TERM_O) ? TERM_O : cur_idx + 1'b1;
        end
    end

    // One count per run: only the edge that enters a terminal state from elsewhere.
    assign inc = (kind != K_BAD) && (nxt_idx != cur_idx) &&
                 ((nxt_idx == TERM_Z) || (nxt_idx == TERM_O));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    count <= '0;
        else if (clr_cnt)              count <= '0;
        else if (inc && (count != '1)) count <= count + 1'b1;
    end

    assign z         = ((kind == K_ZERO) && (cur_idx == TERM_Z)) ||
                       ((kind == K_ONE)  && (cur_idx == TERM_O));
    assign run_val   = (kind == K_ONE);
    assign state     = cur_state;
    assign run_count = count;
endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised successor to the team's two-state-encoding sequence detector.
- Asserts z when input w has held the same value for RUN_LEN consecutive enabled samples; z stays high while the run continues.
- State encoding is selectable (binary or one-hot) so both flavours come from one RTL source.
- Adds sample-enable, a saturating run counter with clear, and an illegal-state recovery path; the FSM state is exported for board LEDs.

Parameters:
- RUN_LEN, 2, run length required for detection; legal range 1..15.
- ONE_HOT, 0, 0 = binary state encoding, 1 = one-hot state encoding.
- CNT_W, 8, width of run_count.
- STATE_W (derived localparam, not overridable): ONE_HOT ? 2*RUN_LEN+1 : clog2(2*RUN_LEN+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample qualifier; w is sampled only on edges where en=1.
- w  input  1  serial data input.
- clr_cnt  input  1  synchronous clear of run_count.
- z  output  1  detect flag (Moore).
- run_val  output  1  value of the current run (1 in O states, else 0).
- state  output  STATE_W  current FSM state code.
- run_count  output  CNT_W  number of completed detections, saturating.

Behaviour:
- States: IDLE; Z1..Z_N (k consecutive 0s, N=RUN_LEN); O1..O_N (k consecutive 1s). Total 2N+1 states.
- Codes:
  - Binary: IDLE=0, Zk=k, Ok=N+k.
  - One-hot: bit index = the binary code value, e.g. IDLE = bit0 set only.
- Reset (reset=0, asynchronous): state=IDLE, z=0, run_val=0, run_count=0. Release is synchronous to the next clk edge.
- en=0: state and run_count hold. clr_cnt is still honoured.
- en=1, w=0:
  - IDLE or any Ok -> Z1.
  - Zk (k<N) -> Z(k+1).
  - Z_N -> Z_N.
- en=1, w=1: symmetric, over the O states.
- z=1 iff state is Z_N or O_N. Moore output from the registered state, so z rises the cycle after the edge that captured the N-th equal sample.
- run_val=1 iff state is one of O1..O_N.
- RUN_LEN=1: every enabled sample lands in Z1 or O1, so z=1 from the first enabled sample onward.
- run_count:
  - Increments by 1 on an edge where next state is terminal (Z_N/O_N) and current state differs from next state. One count per run, not per cycle.
  - A direct O_N->Z_N transition (RUN_LEN=1 only) counts.
  - Saturates at 2^CNT_W-1.
  - clr_cnt=1 forces 0 and has priority over a coincident increment.
- Illegal states go to IDLE on the next clk edge regardless of en; z=0 while illegal. Illegal means binary codes >2N, or a one-hot word with zero or more than one bit set.
- Reset mid-run discards partial runs immediately; the count is cleared.

Test Plan:
- RUN_LEN=2, ONE_HOT=0, en=1, w=0,0,0,1,1 -> state 1,2,2,3,4; z 0,1,1,0,1; run_count 0,1,1,1,2.
- RUN_LEN=2, ONE_HOT=1, same stimulus -> state 00010,00100,00100,01000,10000; z/run_count identical to the binary case.
- RUN_LEN=4, w=1,1,1,0,1,1,1,1 with en=1 -> z first high after the 8th edge; run_count=1; run_val=1.
- en toggles 1,0,0,1 with w=1 held, RUN_LEN=2 -> state O1 held through the en=0 cycles, O2 after the 4th edge, z=1.
- CNT_W=2, RUN_LEN=1, alternating w for 6 edges -> run_count 1,2,3,3,3,3. Then clr_cnt=1 on the same edge as a run entry -> run_count=0.
- Assert reset low mid-run in state O2 (z=1) -> z, state, and run_count go to 0 immediately without a clock. Force binary state code 7 with RUN_LEN=2 -> IDLE on the next edge.
